// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character-LCD engine: FSM states,
// power-up initialisation ROM and small helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int unsigned INIT_LEN   = 4;
    localparam int unsigned INIT_IDX_W = $clog2(INIT_LEN);

    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_CLEAR;
            default: return LCD_ENTRY;
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

    function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every LCD timing phase; done is high
// while the count sits at zero.
module lcd_timer #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write engine: runs the power-up init sequence, then turns each
// accepted command/character byte into setup, EN pulse, hold and execution wait.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYC = 2000000,
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned EN_HIGH_CYC   = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned CMD_WAIT_CYC  = 2000,
    parameter int unsigned CLR_WAIT_CYC  = 82000,
    parameter bit          BLON_DEFAULT  = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lcd_valid,
    input  logic       i_lcd_rs,
    input  logic [7:0] i_lcd_data,
    output logic       o_lcd_ready,
    output logic       o_busy,
    output logic       o_lcd_on,
    output logic       o_lcd_blon,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int unsigned MAX_CYC = cyc_max(cyc_max(cyc_max(INIT_WAIT_CYC, SETUP_CYC),
                                                      cyc_max(EN_HIGH_CYC, HOLD_CYC)),
                                              cyc_max(CMD_WAIT_CYC, CLR_WAIT_CYC));
    localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

    // Counter load values are N-1: the phase ends on the cycle the count reads zero.
    localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

    lcd_state_e            state_q, state_d;
    logic                  rs_q, rs_d;
    logic [7:0]            data_q, data_d;
    logic [INIT_IDX_W-1:0] idx_q, idx_d;
    logic                  init_q, init_d;
    logic                  on_q, blon_q;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_done;

    lcd_timer #(
        .WIDTH   (CNT_W),
        .RST_VAL (INIT_LD)
    ) u_timer (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        data_d   = data_q;
        idx_d    = idx_q;
        init_d   = init_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_PWRUP: if (tmr_done) begin
                state_d  = ST_SETUP;
                rs_d     = 1'b0;
                data_d   = init_rom('0);
                idx_d    = '0;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            ST_IDLE: if (i_lcd_valid) begin
                state_d  = ST_SETUP;
                rs_d     = i_lcd_rs;
                data_d   = i_lcd_data;
                tmr_load = 1'b1;
                tmr_val  = SETUP_LD;
            end
            ST_SETUP: if (tmr_done) begin
                state_d  = ST_EN_HI;
                tmr_load = 1'b1;
                tmr_val  = EN_LD;
            end
            ST_EN_HI: if (tmr_done) begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            ST_HOLD: if (tmr_done) begin
                state_d  = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = is_clr_home(rs_q, data_q) ? CLR_LD : CMD_LD;
            end
            ST_WAIT: if (tmr_done) begin
                if (init_q && (idx_q != INIT_IDX_W'(INIT_LEN - 1))) begin
                    // Next init entry goes straight to SETUP with no gap cycle.
                    state_d  = ST_SETUP;
                    idx_d    = idx_q + INIT_IDX_W'(1);
                    rs_d     = 1'b0;
                    data_d   = init_rom(idx_q + INIT_IDX_W'(1));
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end else begin
                    state_d = ST_IDLE;
                    init_d  = 1'b0;
                end
            end
            default: begin
                state_d  = ST_PWRUP;
                tmr_load = 1'b1;
                tmr_val  = INIT_LD;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_PWRUP;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            idx_q   <= '0;
            init_q  <= 1'b1;
            on_q    <= 1'b0;
            blon_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            init_q  <= init_d;
            on_q    <= 1'b1;
            blon_q  <= BLON_DEFAULT;
        end
    end

    assign o_lcd_ready = (state_q == ST_IDLE);
    assign o_busy      = ~o_lcd_ready;
    assign o_lcd_en    = (state_q == ST_EN_HI);
    assign o_lcd_rs    = rs_q;
    assign o_lcd_data  = data_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_on    = on_q;
    assign o_lcd_blon  = blon_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters; an expected-byte
// queue is filled on accept and drained by an EN-pulse monitor.
module tb_lcd_ctrl;

    localparam int unsigned INIT_WAIT_CYC = 20;
    localparam int unsigned SETUP_CYC     = 1;
    localparam int unsigned EN_HIGH_CYC   = 3;
    localparam int unsigned HOLD_CYC      = 1;
    localparam int unsigned CMD_WAIT_CYC  = 5;
    localparam int unsigned CLR_WAIT_CYC  = 10;

    localparam int XFER_CMD = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + CMD_WAIT_CYC;
    localparam int XFER_CLR = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + CLR_WAIT_CYC;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_lcd_valid = 1'b0;
    logic       i_lcd_rs = 1'b0;
    logic [7:0] i_lcd_data = 8'h00;
    logic       o_lcd_ready, o_busy, o_lcd_on, o_lcd_blon;
    logic       o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .INIT_WAIT_CYC (INIT_WAIT_CYC),
        .SETUP_CYC     (SETUP_CYC),
        .EN_HIGH_CYC   (EN_HIGH_CYC),
        .HOLD_CYC      (HOLD_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLR_WAIT_CYC  (CLR_WAIT_CYC),
        .BLON_DEFAULT  (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_lcd_valid (i_lcd_valid),
        .i_lcd_rs    (i_lcd_rs),
        .i_lcd_data  (i_lcd_data),
        .o_lcd_ready (o_lcd_ready),
        .o_busy      (o_busy),
        .o_lcd_on    (o_lcd_on),
        .o_lcd_blon  (o_lcd_blon),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_data  (o_lcd_data)
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    pulses = 0;
    int    rise_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // EN-pulse monitor: each rising EN must match the oldest expected byte.
    logic  prev_en = 1'b0;
    int    hi_cnt = 0;
    xfer_t cur = '0;

    always @(negedge clk) begin
        if (i_rst) begin
            prev_en = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (o_lcd_en && !prev_en) begin
                pulses++;
                rise_cyc = cyc;
                hi_cnt   = 0;
                check("pulse_expected", 32'(exp_q.size() != 0), 1);
                cur = (exp_q.size() != 0) ? exp_q.pop_front() : xfer_t'('0);
                check("pulse_byte", {o_lcd_rs, o_lcd_data}, cur);
                check("pulse_rw_on", {o_lcd_rw, o_lcd_on}, 2'b01);
            end
            if (o_lcd_en) begin
                hi_cnt++;
                check("en_byte_stable", {o_lcd_rs, o_lcd_data}, cur);
            end
            if (!o_lcd_en && prev_en) check("en_width", hi_cnt, EN_HIGH_CYC);
            prev_en = o_lcd_en;
        end
    end

    task automatic power_up(input string tag);
        int n;
        int base;
        i_rst = 1'b1;
        i_lcd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_pins"},
              {o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_on, o_lcd_blon, o_lcd_ready, o_busy}, 7'b0000001);
        check({tag, "_rst_data"}, o_lcd_data, 8'h00);
        exp_q.delete();
        exp_q.push_back(xfer_t'({1'b0, 8'h38}));
        exp_q.push_back(xfer_t'({1'b0, 8'h0C}));
        exp_q.push_back(xfer_t'({1'b0, 8'h01}));
        exp_q.push_back(xfer_t'({1'b0, 8'h06}));
        base = pulses;
        i_rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) check({tag, "_on_blon"}, {o_lcd_on, o_lcd_blon}, 2'b11);
        end while (!o_lcd_ready && n < 500);
        check({tag, "_ready_cycle"}, n, 65);
        check({tag, "_init_pulses"}, pulses - base, 4);
        check({tag, "_init_drained"}, exp_q.size(), 0);
    endtask

    // Presents one request, waits for acceptance, then measures accept-to-ready.
    // With hold set, valid stays high afterwards carrying the next byte.
    task automatic xfer(input string tag, input logic rs, input logic [7:0] d, input int exp_lat,
                        input bit hold, input logic nrs, input logic [7:0] nd);
        int w;
        int n;
        int acc;
        i_lcd_valid = 1'b1;
        i_lcd_rs    = rs;
        i_lcd_data  = d;
        w = 0;
        while (!o_lcd_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept"}, o_lcd_ready, 1'b1);
        exp_q.push_back(xfer_t'({rs, d}));
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (hold) begin
            i_lcd_rs   = nrs;
            i_lcd_data = nd;
        end else begin
            i_lcd_valid = 1'b0;
        end
        check({tag, "_setup_pins"}, {o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_ready, o_busy},
              {1'b0, rs, d, 1'b0, 1'b1});
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!o_lcd_ready && n < 300);
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_en_start"}, rise_cyc - acc, 1);
        check({tag, "_byte_at_ready"}, {o_lcd_rs, o_lcd_data}, {rs, d});
    endtask

    initial begin
        int base;
        int w;

        // Power-up init sequence.
        power_up("pwrup");

        // Character and command latencies.
        xfer("char_41", 1'b1, 8'h41, XFER_CMD, 1'b0, 1'b0, 8'h00);
        xfer("clear",   1'b0, 8'h01, XFER_CLR, 1'b0, 1'b0, 8'h00);
        xfer("ddram80", 1'b0, 8'h80, XFER_CMD, 1'b0, 1'b0, 8'h00);

        // Busy hold-off and back-to-back accepts.
        base = pulses;
        xfer("hold_a", 1'b1, 8'h41, XFER_CMD, 1'b1, 1'b1, 8'h42);
        xfer("hold_b", 1'b1, 8'h42, XFER_CMD, 1'b0, 1'b0, 8'h00);
        check("b2b_pulses", pulses - base, 2);
        check("b2b_drained", exp_q.size(), 0);

        // Clear/home decode boundaries.
        xfer("home_02", 1'b0, 8'h02, XFER_CLR, 1'b0, 1'b0, 8'h00);
        xfer("home_03", 1'b0, 8'h03, XFER_CLR, 1'b0, 1'b0, 8'h00);
        xfer("cmd_04",  1'b0, 8'h04, XFER_CMD, 1'b0, 1'b0, 8'h00);
        xfer("char_01", 1'b1, 8'h01, XFER_CMD, 1'b0, 1'b0, 8'h00);

        // Reset while EN is high.
        i_lcd_valid = 1'b1;
        i_lcd_rs    = 1'b1;
        i_lcd_data  = 8'h55;
        check("rstmid_ready", o_lcd_ready, 1'b1);
        exp_q.push_back(xfer_t'({1'b1, 8'h55}));
        @(posedge clk);
        @(negedge clk);
        i_lcd_valid = 1'b0;
        w = 0;
        while (!o_lcd_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rstmid_en_high", o_lcd_en, 1'b1);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_pins", {o_lcd_en, o_lcd_data, o_lcd_ready, o_lcd_on}, 11'h0);
        power_up("repwr");

        xfer("post_rst", 1'b1, 8'h5A, XFER_CMD, 1'b0, 1'b0, 8'h00);
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
Responder-side HD44780 character-LCD engine that sits behind the LSU's LCD output register. It accepts one byte per valid/ready handshake from the store path, as command (RS=0) or character (RS=1). It then generates the setup, enable-pulse, hold and execution-wait timing on the LCD pins, so software no longer bit-bangs EN. After reset it runs the LCD power-up initialisation autonomously.

Parameters:
INIT_WAIT_CYC, 2000000, power-up delay before first init command (40 ms at 50 MHz)
SETUP_CYC, 2, RS/DATA valid before EN rises
EN_HIGH_CYC, 12, EN high width
HOLD_CYC, 2, RS/DATA held after EN falls
CMD_WAIT_CYC, 2000, execution wait for normal commands and characters (40 us)
CLR_WAIT_CYC, 82000, execution wait for clear/home (1.64 ms)
BLON_DEFAULT, 1, backlight state after reset release

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_lcd_valid  in  1  request from LSU LCD store decode
i_lcd_rs  in  1  0 = command, 1 = character data
i_lcd_data  in  8  byte to transfer
o_lcd_ready  out  1  engine idle; a request is accepted when valid && ready
o_busy  out  1  inverse of ready, readable by LSU as a status bit
o_lcd_on  out  1  LCD power
o_lcd_blon  out  1  backlight
o_lcd_en  out  1  LCD enable strobe
o_lcd_rs  out  1  LCD register select
o_lcd_rw  out  1  LCD read/write, tied 0 (write only)
o_lcd_data  out  8  LCD data bus

Behaviour:
- Clock and reset: one clock (i_clk). Reset is synchronous and active-high (i_rst).
- Reset values: en=0, rs=0, rw=0, data=8'h00, on=0, blon=0, ready=0, busy=1, state=PWRUP. on=1 and blon=BLON_DEFAULT from the first cycle after reset is released.
- States: PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT.
- PWRUP: counts INIT_WAIT_CYC cycles, then goes to INIT with init index 0.
- INIT: loads ROM entry idx into rs/data (rs=0) and enters SETUP. Sequence is 0x38, 0x0C, 0x01, 0x06. After entry 3 completes WAIT, go to IDLE. Consecutive entries have no gap cycles (WAIT exit goes straight to SETUP of the next entry; the INIT state occupies no cycle of its own).
- IDLE: ready=1. On valid&&ready at edge k, latch i_lcd_rs/i_lcd_data; state=SETUP from cycle k+1 and ready=0.
- SETUP: SETUP_CYC cycles, en=0, rs/data driven.
- EN_HI: EN_HIGH_CYC cycles, en=1.
- HOLD: HOLD_CYC cycles, en=0, rs/data unchanged.
- WAIT: wait length is CLR_WAIT_CYC if rs=0 and data[7:2]==0 (clear/home), else CMD_WAIT_CYC.
- Latency: accept to ready=1 is exactly SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait cycles.
- rs/data change only on entry to SETUP. They are stable through SETUP, EN_HI, HOLD and WAIT.
- Handshake: the initiator holds valid/rs/data until accepted. Valid while ready=0 has no effect and is not queued. Exactly one transfer per handshake cycle. Back-to-back requests are allowed: a new accept may occur on the first ready cycle.
- Reset asserted in any state: all outputs take reset values at the next edge, so en drops within one cycle. The init sequence reruns from PWRUP.
- rw is constant 0; no busy-flag read.
- Counter: a single down-counter, width $clog2(max of all parameters)+1. Loaded with N-1 on state entry; state exits when the count reaches 0. Any parameter of 0 is illegal; the parameter minimum is 1.

Decomposition:
- lcd_pkg shared include:
  - state encodings
  - init ROM constants (LCD_FUNC_SET 8'h38, LCD_DISP_ON 8'h0C, LCD_CLEAR 8'h01, LCD_ENTRY 8'h06)
  - INIT_LEN=4
- Sub-module lcd_timer: loadable down-counter with load value and done flag. It is instantiated once and shared by all states.
- The FSM and datapath stay in lcd_ctrl.

Test Plan:
All tests use INIT_WAIT_CYC=20, SETUP_CYC=1, EN_HIGH_CYC=3, HOLD_CYC=1, CMD_WAIT_CYC=5, CLR_WAIT_CYC=10.
1. Power-up: release reset at cycle 0 -> en pulses carry data 0x38, 0x0C, 0x01, 0x06 with rs=0, each en high exactly 3 cycles. ready first =1 at cycle 65 (20 + 4*5 + 5+5+10+5); on=1 and rw=0 throughout.
2. Character: valid, rs=1, data=0x41 accepted at cycle k -> en=1 during k+2..k+4 with rs=1 and data=0x41 stable from k+1 to ready. ready=1 again at k+11.
3. Clear: rs=0, data=0x01 -> wait uses CLR_WAIT; ready returns 15 cycles after accept. Command 0x80 -> ready after 10.
4. Busy hold-off: valid with 0x42 held high during a transfer -> 0x42 appears on the pins only after ready=1. Exactly one en pulse per accepted request; two back-to-back requests give two pulses with no lost byte.
5. Reset mid-transfer: assert i_rst while en=1 -> en=0 and data=0x00 at the next edge. After release, the full init sequence repeats and ready rises at cycle 65 again.
6. Clear/home boundary: rs=0 with data 0x02 and 0x03 -> 10-cycle wait. Data 0x04 -> 5-cycle wait. rs=1 with data 0x01 -> 5-cycle wait.
